// File: rtl/divider_n_if.sv
// Operand/result handshake bundle for divider_n.
// With DIVIDER_N_SIGNED_EN defined, the bundle also carries i_Signed.
interface divider_n_if #(
    parameter int N = 32
);
    logic         i_Valid;
    logic         o_Ready;
    logic [N-1:0] i_Dividend;
    logic [N-1:0] i_Divisor;
    logic         o_Valid;
    logic         i_Ready;
    logic [N-1:0] o_Quotient;
    logic [N-1:0] o_Remainder;
    logic         o_DivByZero;
    logic         o_Busy;
`ifdef DIVIDER_N_SIGNED_EN
    logic         i_Signed;

    // Requester / result consumer side
    modport master (
        output i_Valid, i_Dividend, i_Divisor, i_Ready, i_Signed,
        input  o_Ready, o_Valid, o_Quotient, o_Remainder, o_DivByZero, o_Busy
    );

    // Divider side
    modport slave (
        input  i_Valid, i_Dividend, i_Divisor, i_Ready, i_Signed,
        output o_Ready, o_Valid, o_Quotient, o_Remainder, o_DivByZero, o_Busy
    );
`else
    // Requester / result consumer side
    modport master (
        output i_Valid, i_Dividend, i_Divisor, i_Ready,
        input  o_Ready, o_Valid, o_Quotient, o_Remainder, o_DivByZero, o_Busy
    );

    // Divider side
    modport slave (
        input  i_Valid, i_Dividend, i_Divisor, i_Ready,
        output o_Ready, o_Valid, o_Quotient, o_Remainder, o_DivByZero, o_Busy
    );
`endif
endinterface

// File: rtl/divider_n.sv
// Multi-cycle N-bit restoring divider: one quotient bit per clock, fixed
// latency of N cycles from acceptance to result valid.
// Optional macro DIVIDER_N_SIGNED_EN adds i_Signed and two's-complement
// operation (magnitude divide, sign fix-up on the final iteration).
module divider_n #(
    parameter int N = 32
) (
    input  logic       i_Clock,
    input  logic       i_ResetN,
    divider_n_if.slave div_if
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int            CW        = $clog2(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] iter_cnt;
    logic [N-1:0]  divisor_q;
    logic [N-1:0]  quo_sr;
    logic [N-1:0]  rem_q;

    logic [N:0]    rem_shift;
    logic [N:0]    trial;
    logic          trial_ok;
    logic [N-1:0]  quo_next;
    logic [N-1:0]  rem_next;

    logic [N-1:0]  dividend_mag;
    logic [N-1:0]  divisor_mag;
    logic [N-1:0]  quo_final;
    logic [N-1:0]  rem_final;

    assign div_if.o_Ready = (state == IDLE);

    // One restoring step: shift {R,Q} left, trial-subtract D at N+1 bits
    always_comb begin
        rem_shift = {rem_q, quo_sr[N-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        trial_ok  = ~trial[N];
        quo_next  = {quo_sr[N-2:0], trial_ok};
        rem_next  = trial_ok ? trial[N-1:0] : rem_shift[N-1:0];
    end

`ifdef DIVIDER_N_SIGNED_EN
    logic neg_quo;
    logic neg_rem;

    // Operand magnitudes on acceptance and sign fix-up of the final result.
    // MIN / -1 needs no special case: |MIN| / 1 = MIN with equal signs.
    always_comb begin
        dividend_mag = (div_if.i_Signed && div_if.i_Dividend[N-1]) ? -div_if.i_Dividend
                                                                    : div_if.i_Dividend;
        divisor_mag  = (div_if.i_Signed && div_if.i_Divisor[N-1])  ? -div_if.i_Divisor
                                                                    : div_if.i_Divisor;
        if (div_if.o_DivByZero) begin
            quo_final = '1;
        end else begin
            quo_final = neg_quo ? -quo_next : quo_next;
        end
        rem_final = neg_rem ? -rem_next : rem_next;
    end
`else
    // Unsigned only: operands and results pass straight through
    always_comb begin
        dividend_mag = div_if.i_Dividend;
        divisor_mag  = div_if.i_Divisor;
        quo_final    = quo_next;
        rem_final    = rem_next;
    end
`endif

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge i_Clock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state              <= IDLE;
            iter_cnt           <= '0;
            divisor_q          <= '0;
            quo_sr             <= '0;
            rem_q              <= '0;
            div_if.o_Valid     <= 1'b0;
            div_if.o_Busy      <= 1'b0;
            div_if.o_Quotient  <= '0;
            div_if.o_Remainder <= '0;
            div_if.o_DivByZero <= 1'b0;
`ifdef DIVIDER_N_SIGNED_EN
            neg_quo            <= 1'b0;
            neg_rem            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (div_if.i_Valid) begin
                        divisor_q          <= divisor_mag;
                        quo_sr             <= dividend_mag;
                        rem_q              <= '0;
                        iter_cnt           <= '0;
                        div_if.o_DivByZero <= (div_if.i_Divisor == '0);
                        div_if.o_Busy      <= 1'b1;
`ifdef DIVIDER_N_SIGNED_EN
                        neg_quo <= div_if.i_Signed &&
                                   (div_if.i_Dividend[N-1] ^ div_if.i_Divisor[N-1]);
                        neg_rem <= div_if.i_Signed && div_if.i_Dividend[N-1];
`endif
                        state              <= BUSY;
                    end
                end
                BUSY: begin
                    quo_sr   <= quo_next;
                    rem_q    <= rem_next;
                    iter_cnt <= iter_cnt + CW'(1);
                    if (iter_cnt == LAST_ITER) begin
                        div_if.o_Quotient  <= quo_final;
                        div_if.o_Remainder <= rem_final;
                        div_if.o_Valid     <= 1'b1;
                        div_if.o_Busy      <= 1'b0;
                        state              <= DONE;
                    end
                end
                DONE: begin
                    if (div_if.i_Ready) begin
                        div_if.o_Valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_n.sv
// Self-checking bench for divider_n (N=32): directed cases plus randomized
// operations compared against an arithmetic reference model.
// Honours DIVIDER_N_SIGNED_EN for the signed cases.
module tb_divider_n;
    localparam int N = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    divider_n_if #(.N(N)) bus ();

    divider_n #(.N(N)) dut (
        .i_Clock (clk),
        .i_ResetN(rst_n),
        .div_if  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic from the divide rules
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn,
                                    output logic [N-1:0] q, output logic [N-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = N'(sa / sb);
            r  = N'(sa % sb);
        end
    endfunction

    // Issue one operation, check latency/result, optionally hold off the
    // consumer, optionally inject a stray request while busy.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn,
                          input int hold, input bit inject);
        logic [N-1:0] eq, er;
        int wait_cnt;
        int lat;
        ref_div(a, b, sgn, eq, er);
        bus.i_Dividend = a;
        bus.i_Divisor  = b;
`ifdef DIVIDER_N_SIGNED_EN
        bus.i_Signed   = sgn;
`endif
        bus.i_Valid    = 1'b1;
        wait_cnt = 0;
        while (!bus.o_Ready && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!bus.o_Ready) begin
            check_eq("accept_timeout", 64'(bus.o_Ready), 64'd1);
            bus.i_Valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.i_Valid = 1'b0;
        check_eq("busy_after_accept", 64'(bus.o_Busy), 64'd1);
        check_eq("ready_after_accept", 64'(bus.o_Ready), 64'd0);
        lat = 0;
        while (!bus.o_Valid && lat < 200) begin
            if (inject && lat == 5) begin
                bus.i_Dividend = 6;
                bus.i_Divisor  = 2;
                bus.i_Valid    = 1'b1;
                check_eq("ready_in_busy", 64'(bus.o_Ready), 64'd0);
            end
            if (inject && lat == 6) bus.i_Valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bus.i_Valid = 1'b0;
        check_eq("latency", 64'(lat), 64'(N));
        check_eq("quotient", 64'(bus.o_Quotient), 64'(eq));
        check_eq("remainder", 64'(bus.o_Remainder), 64'(er));
        check_eq("div_by_zero", 64'(bus.o_DivByZero), 64'(b == '0));
        check_eq("busy_in_done", 64'(bus.o_Busy), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(bus.o_Valid), 64'd1);
            check_eq("hold_ready", 64'(bus.o_Ready), 64'd0);
            check_eq("hold_quotient", 64'(bus.o_Quotient), 64'(eq));
            check_eq("hold_remainder", 64'(bus.o_Remainder), 64'(er));
        end
        bus.i_Ready = 1'b1;
        @(posedge clk); #1;
        bus.i_Ready = 1'b0;
        check_eq("valid_after_handshake", 64'(bus.o_Valid), 64'd0);
        check_eq("ready_after_handshake", 64'(bus.o_Ready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        bit rs;
        bus.i_Valid    = 1'b0;
        bus.i_Ready    = 1'b0;
        bus.i_Dividend = '0;
        bus.i_Divisor  = '0;
`ifdef DIVIDER_N_SIGNED_EN
        bus.i_Signed   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(bus.o_Valid), 64'd0);
        check_eq("rst_busy", 64'(bus.o_Busy), 64'd0);
        check_eq("rst_quotient", 64'(bus.o_Quotient), 64'd0);
        check_eq("rst_remainder", 64'(bus.o_Remainder), 64'd0);
        check_eq("rst_dbz", 64'(bus.o_DivByZero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_reset", 64'(bus.o_Ready), 64'd1);

        run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
        run_op(32'hDEADBEEF, 32'd0, 1'b0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 10, 1'b0);

        // Stray request while busy must not spawn a second result
        run_op(32'd1000, 32'd10, 1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("no_second_result", 64'(bus.o_Valid), 64'd0);
            check_eq("idle_not_busy", 64'(bus.o_Busy), 64'd0);
        end

        // Reset in mid-iteration abandons the operation
        check_eq("pre_reset_ready", 64'(bus.o_Ready), 64'd1);
        bus.i_Dividend = 32'd50;
        bus.i_Divisor  = 32'd5;
        bus.i_Valid    = 1'b1;
        @(posedge clk); #1;
        bus.i_Valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("mid_busy", 64'(bus.o_Busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus.o_Valid), 64'd0);
        check_eq("mid_rst_busy", 64'(bus.o_Busy), 64'd0);
        check_eq("mid_rst_quotient", 64'(bus.o_Quotient), 64'd0);
        check_eq("mid_rst_remainder", 64'(bus.o_Remainder), 64'd0);
        check_eq("mid_rst_dbz", 64'(bus.o_DivByZero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check_eq("abandoned_no_result", 64'(bus.o_Valid), 64'd0);
        end
        run_op(32'd9, 32'd3, 1'b0, 0, 1'b0);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = N'($urandom_range(1, 255));
                3, 4:    rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
`ifdef DIVIDER_N_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, $urandom_range(0, 3), 1'b0);
        end

`ifdef DIVIDER_N_SIGNED_EN
        run_op(-32'sd7, 32'd2, 1'b1, 0, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        run_op(-32'sd5, 32'd0, 1'b1, 0, 1'b0);
        run_op(32'd7, -32'sd2, 1'b1, 0, 1'b0);
        run_op(32'hFFFFFFF9, 32'd2, 1'b0, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
